// File: rtl/mem_loader.sv
`timescale 1ns/1ps
// Purpose: turns a serial byte stream into little-endian words, fills imem then dmem, then releases the CPU.
// Latency: a word's write pulse appears one clock after its 4th byte is accepted.
// Backpressure: in_ready is high only while loading; no stall inside a load, so bytes may arrive every cycle.
module mem_loader #(
    parameter int depth = 32,
    parameter int width = 32    // only 32-bit words are supported
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    output logic                     in_ready,
    output logic                     imem_we,
    output logic [$clog2(depth)-1:0] imem_waddr,
    output logic [width-1:0]         imem_wdata,
    output logic                     dmem_we,
    output logic [$clog2(depth)-1:0] dmem_waddr,
    output logic [width-1:0]         dmem_wdata,
    output logic                     cpu_run,
    output logic                     busy
);

    localparam int AW = $clog2(depth);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_I = 2'd1,
        LOAD_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]     word_cnt_q, word_cnt_d;
    logic [23:0]       buf_q, buf_d;          // first three bytes of the word being assembled
    logic              imem_we_q, imem_we_d;
    logic [AW-1:0]     imem_waddr_q, imem_waddr_d;
    logic [width-1:0]  imem_wdata_q, imem_wdata_d;
    logic              dmem_we_q, dmem_we_d;
    logic [AW-1:0]     dmem_waddr_q, dmem_waddr_d;
    logic [width-1:0]  dmem_wdata_q, dmem_wdata_d;
    logic              cpu_run_q, cpu_run_d;

    logic              loading;
    logic              accept;
    logic              last_word;
    logic [width-1:0]  full_word;

    assign loading   = (state_q == LOAD_I) || (state_q == LOAD_D);
    assign accept    = in_valid && loading;
    assign last_word = (word_cnt_q == AW'(depth - 1));
    // The 4th byte goes straight to the top lane; the lower three come from the buffer.
    assign full_word = width'({in_byte, buf_q});

    // Next-state, byte assembly and write-port selection.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        buf_d        = buf_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_waddr_d = dmem_waddr_q;
        dmem_wdata_d = dmem_wdata_q;
        cpu_run_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_I;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                end
            end
            LOAD_I, LOAD_D: begin
                if (accept) begin
                    if (byte_cnt_q != 2'd3) begin
                        case (byte_cnt_q)
                            2'd0:    buf_d[7:0]   = in_byte;
                            2'd1:    buf_d[15:8]  = in_byte;
                            default: buf_d[23:16] = in_byte;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end else begin
                        byte_cnt_d = 2'd0;
                        if (state_q == LOAD_I) begin
                            imem_we_d    = 1'b1;
                            imem_waddr_d = word_cnt_q;
                            imem_wdata_d = full_word;
                        end else begin
                            dmem_we_d    = 1'b1;
                            dmem_waddr_d = word_cnt_q;
                            dmem_wdata_d = full_word;
                        end
                        if (last_word) begin
                            word_cnt_d = '0;
                            state_d    = (state_q == LOAD_I) ? LOAD_D : DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + AW'(1);
                        end
                    end
                end
            end
            default: begin  // DONE
                if (start) begin
                    // Reload: CPU is held again from the next cycle.
                    state_d    = LOAD_I;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                end else begin
                    // First DONE cycle carries the last dmem pulse; run starts after it.
                    cpu_run_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= '0;
            buf_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_waddr_q <= '0;
            dmem_wdata_q <= '0;
            cpu_run_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            buf_q        <= buf_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_waddr_q <= dmem_waddr_d;
            dmem_wdata_q <= dmem_wdata_d;
            cpu_run_q    <= cpu_run_d;
        end
    end

    assign in_ready   = loading;
    assign busy       = loading;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_waddr = dmem_waddr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign cpu_run    = cpu_run_q;

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
// Bench for mem_loader: table-driven first words plus a scoreboard of expected memory writes.
// Stimulus drives 1ns after the rising edge; all DUT outputs are sampled on the falling edge.
// Covers reset state, full/throttled loads, restart, start/reset precedence and mid-load reset.
module tb_mem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [7:0]    in_byte;
    logic          in_ready, imem_we, dmem_we, cpu_run, busy;
    logic [AW-1:0] imem_waddr, dmem_waddr;
    logic [31:0]   imem_wdata, dmem_wdata;

    mem_loader #(.depth(DEPTH), .width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_waddr (dmem_waddr),
        .dmem_wdata (dmem_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endfunction

    // Stream-order bytes of a word and the word they must form.
    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;
    vec_t vtab[4];

    typedef struct {
        bit            is_d;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int            n_iwe = 0, n_dwe = 0, hold_err = 0;
    logic [AW-1:0] last_ia, last_da;
    logic [31:0]   last_id, last_dd;

    // Write monitor: every pulse must match the oldest expectation, one cycle after its 4th byte.
    always @(negedge clk) begin
        if (rst) begin
            last_ia = '0; last_id = '0; last_da = '0; last_dd = '0;
        end else begin
            if (imem_we || dmem_we) begin
                check("we_exclusive", imem_we & dmem_we, 0);
                check("we_has_expectation", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("we_target", {imem_we, dmem_we}, mon_e.is_d ? 2'b01 : 2'b10);
                    check("waddr", imem_we ? imem_waddr : dmem_waddr, mon_e.addr);
                    check("wdata", imem_we ? imem_wdata : dmem_wdata, mon_e.data);
                    check("we_latency", cyc, mon_e.cyc);
                end
            end
            if (imem_we) begin
                n_iwe++; last_ia = imem_waddr; last_id = imem_wdata;
            end else if (imem_waddr !== last_ia || imem_wdata !== last_id) hold_err++;
            if (dmem_we) begin
                n_dwe++; last_da = dmem_waddr; last_dd = dmem_wdata;
            end else if (dmem_waddr !== last_da || dmem_wdata !== last_dd) hold_err++;
        end
    end

    function automatic logic [7:0] gen_byte(int w, int k);
        return 8'((w * 13 + k * 61 + 7) & 255);
    endfunction

    function automatic logic [7:0] byte_for(int w, int k);
        if (w < 4) begin
            case (k)
                0:       return vtab[w].b0;
                1:       return vtab[w].b1;
                2:       return vtab[w].b2;
                default: return vtab[w].b3;
            endcase
        end
        return gen_byte(w, k);
    endfunction

    function automatic logic [31:0] exp_word(int w);
        if (w < 4) return vtab[w].exp;
        return {gen_byte(w, 3), gen_byte(w, 2), gen_byte(w, 1), gen_byte(w, 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted, bounded by a cycle budget.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        in_valid = 1'b1;
        in_byte  = b;
        ok       = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("in_ready_within_budget", ok, 1);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_cpu_run"},    cpu_run,    0);
        check({tag, "_imem_we"},    imem_we,    0);
        check({tag, "_dmem_we"},    dmem_we,    0);
        check({tag, "_imem_waddr"}, imem_waddr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_dmem_waddr"}, dmem_waddr, 0);
        check({tag, "_dmem_wdata"}, dmem_wdata, 0);
    endtask

    // Stream nbytes of the load image; a full image also checks the DONE handover.
    task automatic do_load(input bit do_start, input bit throttle, input bit hold_start, input int nbytes);
        bit ok;
        int w, k;
        n_iwe = 0;
        n_dwe = 0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < nbytes; i++) begin
            w = i / 4;
            k = i % 4;
            if (hold_start && w == DEPTH && k == 0)         start = 1'b1;
            if (hold_start && w == 2 * DEPTH - 1 && k == 0) start = 1'b0;
            if (throttle) repeat ($urandom_range(0, 2)) tick();
            if (throttle && w == 10 && k == 2) repeat (20) tick();
            send_byte(byte_for(w, k), ok);
            if (ok && k == 3)
                exp_q.push_back('{is_d: (w >= DEPTH), addr: AW'(w % DEPTH), data: exp_word(w), cyc: cyc});
        end
        if (nbytes == 8 * DEPTH) begin
            @(negedge clk);
            check("last_dmem_we_in_first_done", dmem_we, 1);
            check("cpu_run_low_in_first_done", cpu_run, 0);
            check("busy_low_in_done", busy, 0);
            @(negedge clk);
            check("cpu_run_after_last_write", cpu_run, 1);
            check("in_ready_low_in_done", in_ready, 0);
            check("imem_pulse_count", n_iwe, DEPTH);
            check("dmem_pulse_count", n_dwe, DEPTH);
            check("scoreboard_drained", exp_q.size(), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vtab[0] = '{b0: 8'h13, b1: 8'h05, b2: 8'h10, b3: 8'h00, exp: 32'h0010_0513};
        vtab[1] = '{b0: 8'hef, b1: 8'hbe, b2: 8'had, b3: 8'hde, exp: 32'hdead_beef};
        vtab[2] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h80, exp: 32'h8000_0000};
        vtab[3] = '{b0: 8'hff, b1: 8'h00, b2: 8'hff, b3: 8'h00, exp: 32'h00ff_00ff};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;

        // Bytes offered in IDLE are not taken.
        in_valid = 1'b1; in_byte = 8'haa;
        tick();
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) tick();
        check("idle_no_write", n_iwe + n_dwe, 0);

        // Continuous full load.
        do_load(1'b1, 1'b0, 1'b0, 8 * DEPTH);

        // Bytes offered in DONE are not taken.
        in_valid = 1'b1; in_byte = 8'h55;
        repeat (3) tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("done_in_ready", in_ready, 0);
        check("done_cpu_run_kept", cpu_run, 1);
        @(posedge clk); #1;

        // Restart from DONE, then a throttled load with start held through LOAD_D.
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("restart_cpu_run", cpu_run, 0);
        check("restart_busy", busy, 1);
        @(posedge clk); #1;
        do_load(1'b0, 1'b1, 1'b1, 8 * DEPTH);

        // Reset and start together in DONE: reset wins.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        check("rst_start_cpu_run", cpu_run, 0);
        check("rst_start_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // Reset after two bytes of word 5.
        do_load(1'b1, 1'b0, 1'b0, 22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("midload_rst");
        check("midload_rst_scoreboard", exp_q.size(), 0);
        @(posedge clk); #1;
        repeat (4) tick();
        check("midload_rst_write_count", n_iwe + n_dwe, 5);

        // Fresh load after reset starts again at address 0.
        do_load(1'b1, 1'b0, 1'b0, 8 * DEPTH);

        check("waddr_wdata_hold_violations", hold_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter depth, default 32, meaning words per memory (instruction and data).
REQ-002 SHALL have parameter width, default 32, meaning memory word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begin a load sequence; sampled as a level.
REQ-006 SHALL have port in_valid, input, 1 bit: in_byte carries a valid byte.
REQ-007 SHALL have port in_byte, input, 8 bits: serial program/data byte stream.
REQ-008 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we, output, 1 bit: instruction-memory write enable.
REQ-010 SHALL have port imem_waddr, output, $clog2(depth) bits: instruction-memory word address.
REQ-011 SHALL have port imem_wdata, output, width bits: instruction-memory write data.
REQ-012 SHALL have port dmem_we, output, 1 bit: data-memory write enable.
REQ-013 SHALL have port dmem_waddr, output, $clog2(depth) bits: data-memory word address.
REQ-014 SHALL have port dmem_wdata, output, width bits: data-memory write data.
REQ-015 SHALL have port cpu_run, output, 1 bit: 1 releases the processor (drives its rst input); 0 holds it.
REQ-016 SHALL have port busy, output, 1 bit: high in LOAD_I or LOAD_D.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_I, LOAD_D, DONE.
REQ-018 SHALL move IDLE->LOAD_I when start=1, clearing byte_cnt (2 bits) and word_cnt to 0.
REQ-019 SHALL drive in_ready=1 exactly in LOAD_I and LOAD_D, combinationally from state.
REQ-020 SHALL accept a byte only on in_valid & in_ready in the same cycle; no byte is dropped or duplicated.
REQ-021 SHALL assemble words little-endian: the k-th accepted byte (k=0..3) lands in bits [8k+7:8k].
REQ-022 SHALL, on acceptance of the 4th byte, register the complete word and address word_cnt into the *_wdata/*_waddr outputs.
REQ-023 SHALL, for that word, pulse the matching *_we for exactly one cycle, the cycle after the 4th byte; latency is 1 clock.
REQ-024 SHALL select imem_* in LOAD_I and dmem_* in LOAD_D, and never assert both we signals in the same cycle.
REQ-025 SHALL allow back-to-back bytes every cycle with no stall; a write pulse overlaps acceptance of the next word's bytes.
REQ-026 SHALL hold *_waddr/*_wdata stable between write pulses.
REQ-027 SHALL increment word_cnt per completed word; after word depth-1 in LOAD_I, wrap word_cnt to 0 and enter LOAD_D.
REQ-028 SHALL, after word depth-1 in LOAD_D, enter DONE.
REQ-029 SHALL, for the final data word, emit its dmem_we pulse in the first DONE cycle.
REQ-030 SHALL set cpu_run=1 only in DONE, from the cycle after the final dmem_we pulse onward.
REQ-031 SHALL ignore start while in LOAD_I or LOAD_D; the load continues unaffected.
REQ-032 SHALL, on start=1 in DONE, drop cpu_run to 0 next cycle, enter LOAD_I and reload from address 0.
REQ-033 SHALL ignore in_valid in IDLE and DONE; in_ready=0 there.
REQ-034 SHALL retain a partial word (byte_cnt≠0) indefinitely while in_valid=0; there is no timeout.

Reset
REQ-035 SHALL, when rst=1, on the next edge enter IDLE and set byte_cnt=0, word_cnt=0, in_ready=0, imem_we=0, dmem_we=0, all addr/wdata=0, cpu_run=0, busy=0.
REQ-036 SHALL give rst priority over start and in_valid in the same cycle.
REQ-037 SHALL, on rst mid-load, discard the partial word and emit no further we pulses.

Verification
REQ-038 Bench SHALL cover full load: depth=32, 256 bytes streamed continuously -> 32 imem_we pulses at addresses 0..31, then 32 dmem_we pulses at addresses 0..31, cpu_run=1 after the last.
REQ-039 Bench SHALL cover byte order: bytes 0x13,0x05,0x10,0x00 -> imem_wdata=0x00100513 at imem_waddr 0.
REQ-040 Bench SHALL cover throttling: random in_valid gaps, including mid-word -> identical memory contents and address sequence as the continuous case.
REQ-041 Bench SHALL cover reset mid-load: rst after 2 bytes of word 5 -> no write to address 5, all outputs 0; restart writes from address 0.
REQ-042 Bench SHALL cover restart: start in DONE -> cpu_run 0 next cycle, busy 1, first new imem_we at address 0.
REQ-043 Bench SHALL cover precedence: start held during LOAD_D and start+rst in the same cycle -> load undisturbed; reset wins.
